// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg
//   Shared definitions for the instruction fetch stage:
//   fetch FSM state encoding, pcsource codes, default bubble word
//   and a word-alignment helper.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_e;

    localparam logic [1:0]  PCSRC_SEQ = 2'b00;
    localparam logic [1:0]  PCSRC_BR  = 2'b01;
    localparam logic [1:0]  PCSRC_JMP = 2'b10;

    localparam logic [31:0] BUBBLE_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register holding pc4, the instruction word and a
//   valid bit. Flush has priority over load; neither means hold.
// Ports:
//   clk, clrn          clock, asynchronous active-high reset
//   load, flush        capture new entry / insert bubble
//   pc4_in, inst_in    entry captured on load
//   pc4, inst, valid   registered IF/ID contents
module if_id_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] BUBBLE = BUBBLE_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc4_in,
    input  logic [31:0] inst_in,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        valid
);

    logic [31:0] pc4_q, pc4_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush) begin
            pc4_d   = 32'h0;
            inst_d  = BUBBLE;
            valid_d = 1'b0;
        end else if (load) begin
            pc4_d   = pc4_in;
            inst_d  = inst_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            pc4_q   <= 32'h0;
            inst_q  <= BUBBLE;
            valid_q <= 1'b0;
        end else begin
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc4   = pc4_q;
    assign inst  = inst_q;
    assign valid = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   IF stage: owns the PC, issues one request at a time to a
//   variable-latency instruction memory, applies ID redirects and the
//   load-use stall, and feeds the IF/ID register.
// Ports:
//   clk, clrn                   clock, asynchronous active-high reset
//   stall, pcsource, bpc, jpc   hazard stall and redirect from ID
//   imem_req/addr/rdata/valid   instruction memory handshake
//   pc4, inst, id_valid         IF/ID register outputs
//   fetch_stall_cnt             only with IFETCH_PERF_EN defined
//
// state | meaning
// ISSUE | drive imem_req for one cycle at pc
// WAIT  | request outstanding, waiting for imem_valid
// HOLD  | response parked in skid register while stalled
// DRAIN | redirected mid-request; discard the stale response
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = BUBBLE_DEFAULT
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        id_valid
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_q, skid_d;

    logic         redirect;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_inst;

    assign redirect = (pcsource == PCSRC_BR) || (pcsource == PCSRC_JMP);
    assign target   = align_word((pcsource == PCSRC_JMP) ? jpc : bpc);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_inst  = imem_rdata;
        if (redirect) begin
            pc_d       = target;
            ifid_flush = 1'b1;
        end
        case (state_q)
            ST_ISSUE: begin
                // A redirect here suppresses the request, so re-issue from the target.
                state_d = redirect ? ST_ISSUE : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_d = imem_valid ? ST_ISSUE : ST_DRAIN;
                end else if (imem_valid && !stall) begin
                    ifid_load = 1'b1;
                    pc_d      = pc_plus4;
                    state_d   = ST_ISSUE;
                end else if (imem_valid) begin
                    skid_d  = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = ST_ISSUE;
                end else if (!stall) begin
                    ifid_load = 1'b1;
                    ifid_inst = skid_q;
                    pc_d      = pc_plus4;
                    state_d   = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                // Stale response consumed in the same cycle as a redirect
                // must still release DRAIN, otherwise nothing would arrive.
                if (imem_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            state_q <= ST_ISSUE;
            pc_q    <= RESET_PC;
            skid_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            skid_q  <= skid_d;
        end
    end

    assign imem_req  = (state_q == ST_ISSUE) && !redirect && !clrn;
    assign imem_addr = align_word(pc_q);

    if_id_reg #(.BUBBLE(BUBBLE)) u_if_id_reg (
        .clk     (clk),
        .clrn    (clrn),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .pc4_in  (pc_plus4),
        .inst_in (ifid_inst),
        .pc4     (pc4),
        .inst    (inst),
        .valid   (id_valid)
    );

`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q != ST_ISSUE) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            stall_cnt_q <= 32'h0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule
